// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic TX_IDLE = 1'b1;

  // data_xor is the reduction XOR of the word; odd parity inverts it
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-side bundle between Sync_FIFO and the UART transmitter
interface fifo_uart_tx_if #(
  parameter int Width = 8
);

  logic             fifo_empty;
  logic [Width-1:0] fifo_rdata;
  logic             fifo_r_en;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_r_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_r_en
  );

endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter; tick marks the last clk of each bit time
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains Sync_FIFO words and serialises them as UART frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int Width        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  fifo_uart_tx_if.master  bus,
  output logic            tx,
  output logic            busy,
  output logic            tx_done
);

  localparam int IW = $clog2(Width) + 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(Width - 1);

  tx_state_e        state;
  tx_state_e        state_next;
  logic             bit_tick;
  logic             baud_en;
  logic [Width-1:0] shreg;
  logic [IW-1:0]    bit_idx;
  logic             stop_idx;
  logic             last_stop;
  logic             par_bit;
  logic             r_en;

  assign baud_en   = (state == START) || (state == DATA) || (state == PAR) || (state == STOP);
  assign last_stop = (STOP_BITS < 2) || stop_idx;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (baud_en),
    .tick(bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!bus.fifo_empty) state_next = READ;
      READ:  state_next = LOAD;
      LOAD:  state_next = START;
      START: if (bit_tick) state_next = DATA;
      DATA: begin
        if (bit_tick && bit_idx == LAST_BIT) begin
          state_next = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR:   if (bit_tick) state_next = STOP;
      STOP: begin
        if (bit_tick && last_stop) begin
          state_next = bus.fifo_empty ? IDLE : READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    tx_done = (state == STOP) && bit_tick && last_stop;
  end

  // tx is always registered; each bit is loaded on the tick that ends the previous one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= TX_IDLE;
      r_en     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      r_en <= (state_next == READ);
      case (state)
        LOAD: begin
          shreg    <= bus.fifo_rdata;
          par_bit  <= parity_bit(^bus.fifo_rdata, PARITY);
          tx       <= 1'b0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
        end
        START: begin
          if (bit_tick) tx <= shreg[0];
        end
        DATA: begin
          if (bit_tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IW'(1);
            if (bit_idx == LAST_BIT) begin
              tx <= (PARITY != PAR_NONE) ? par_bit : TX_IDLE;
            end else begin
              tx <= shreg[1];
            end
          end
        end
        PAR: begin
          if (bit_tick) tx <= TX_IDLE;
        end
        STOP: begin
          if (bit_tick) stop_idx <= ~stop_idx;
        end
        default: tx <= TX_IDLE;
      endcase
    end
  end

  assign bus.fifo_r_en = r_en;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - three transmitter lanes (no/even/odd parity) fed by bench FIFOs
module tb_fifo_uart_tx;

  localparam int C    = 4;
  localparam int W    = 8;
  localparam int NL   = 3;
  localparam int LOGN = 4096;
  localparam int LPAR [NL] = '{0, 1, 2};
  localparam int LSB  [NL] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [NL-1:0] tx, busy, done, ren;

  logic [7:0] fmem [NL][16];
  logic [7:0] frdata [NL] = '{default: 8'h00};
  int         fcnt [NL] = '{default: 0};
  int         frp [NL] = '{default: 0};
  int         fwp [NL] = '{default: 0};

  int n_tests = 0;
  int n_fails = 0;
  int n_print = 0;
  int cyc = 0;
  int rencnt [NL] = '{default: 0};
  int donecnt [NL] = '{default: 0};
  logic [3:0] obs [NL][LOGN];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    fifo_uart_tx_if #(.Width(W)) bus ();
    assign bus.fifo_empty = (fcnt[g] == 0);
    assign bus.fifo_rdata = frdata[g];
    assign ren[g]         = bus.fifo_r_en;

    fifo_uart_tx #(
      .Width(W), .CLKS_PER_BIT(C), .PARITY(LPAR[g]), .STOP_BITS(LSB[g])
    ) dut (
      .clk(clk), .rst(rst), .bus(bus), .tx(tx[g]), .busy(busy[g]), .tx_done(done[g])
    );
  end

  // Sync_FIFO stand-in per lane: depth 16, data_out registered on the popping edge
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      int c;
      c = fcnt[l];
      if (ren[l] && fcnt[l] > 0) begin
        frdata[l] <= fmem[l][frp[l]];
        frp[l] <= (frp[l] + 1) % 16;
        c = c - 1;
      end
      if (wr && fcnt[l] < 16) begin
        fmem[l][fwp[l]] <= wdata;
        fwp[l] <= (fwp[l] + 1) % 16;
        c = c + 1;
      end
      fcnt[l] <= c;
    end
  end

  // Model: per-cycle expected {tx, r_en, busy, done}, built per frame from the line bits
  logic [3:0] expq [NL][$];
  logic [7:0] mq [NL][$];

  function automatic void push_frame(int l, logic [7:0] b);
    int nb;
    logic bits [16];
    nb = 0;
    bits[nb++] = 1'b0;
    for (int k = 0; k < 8; k++) bits[nb++] = b[k];
    if (LPAR[l] != 0) bits[nb++] = (^b) ^ (LPAR[l] == 2);
    for (int k = 0; k < LSB[l]; k++) bits[nb++] = 1'b1;
    expq[l].push_back(4'b1110);
    expq[l].push_back(4'b1010);
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < C; j++)
        expq[l].push_back({bits[k], 1'b0, 1'b1, (k == nb - 1) && (j == C - 1)});
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int l = 0; l < NL; l++) begin
      if (rst) begin
        expq[l].delete();
        expq[l].push_back(4'b1000);
      end else begin
        if (expq[l].size() > 0) void'(expq[l].pop_front());
        if (expq[l].size() == 0) begin
          if (mq[l].size() > 0) push_frame(l, mq[l].pop_front());
          else expq[l].push_back(4'b1000);
        end
      end
      if (wr && clk) mq[l].push_back(wdata);
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int l = 0; l < NL; l++) begin
      logic [3:0] act;
      act = {tx[l], ren[l], busy[l], done[l]};
      if (cyc < LOGN) obs[l][cyc] = act;
      rencnt[l] += int'(ren[l]);
      donecnt[l] += int'(done[l]);
      if (expq[l].size() > 0) begin
        n_tests++;
        if (act !== expq[l][0]) begin
          n_fails++;
          if (n_print < 40) begin
            n_print++;
            $display("FAIL cycle lane%0d @%0d {tx,r_en,busy,done}: got %b expected %b",
                     l, cyc, act, expq[l][0]);
          end
        end
      end
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int find(int l, int from, int pos, logic val);
    for (int c = from; c <= cyc && c < LOGN; c++) if (obs[l][c][pos] == val) return c;
    return -1;
  endfunction

  function automatic int sample(int l, int s, int n);
    int v;
    v = 0;
    for (int k = 0; k < n; k++)
      if (s >= 0 && s + k * C + 2 < LOGN) v |= int'(obs[l][s + k * C + 2][3]) << k;
    return v;
  endfunction

  function automatic int get_byte(int l, int s);
    return (sample(l, s, 9) >> 1) & 8'hFF;
  endfunction

  task automatic write_seq(input logic [7:0] b [$]);
    foreach (b[i]) begin
      wr = 1'b1;
      wdata = b[i];
      @(negedge clk);
    end
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      if (busy == '0 && fcnt[0] == 0 && fcnt[1] == 0 && fcnt[2] == 0) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int base, s, s1, s2, d, r0, rc0, dc0, rb;
    logic [7:0] q [$];

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx[0]), 1);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_r_en", int'(ren[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    rst = 1'b0;

    // empty FIFO: nothing may happen
    repeat (200) @(negedge clk);
    chk("empty_pops", rencnt[0] + rencnt[1] + rencnt[2], 0);

    // single 0xA5
    base = cyc; rc0 = rencnt[0];
    q = '{8'hA5}; write_seq(q); wait_idle();
    s = find(0, base, 3, 1'b0);
    r0 = find(0, base, 2, 1'b1);
    chk("latency", s - r0, 2);
    chk("a5_line", sample(0, s, 10), 'h34A);
    chk("a5_done_at", find(0, s, 0, 1'b1) - s, 39);
    chk("a5_one_pop", rencnt[0] - rc0, 1);
    s1 = find(1, base, 3, 1'b0);
    chk("a5_even_par", (sample(1, s1, 10) >> 9) & 1, 0);
    chk("a5_even_len", find(1, s1, 0, 1'b1) - s1, 43);
    s1 = find(2, base, 3, 1'b0);
    chk("a5_odd_par", (sample(2, s1, 10) >> 9) & 1, 1);
    chk("a5_odd_2stop_len", find(2, s1, 0, 1'b1) - s1, 47);

    // 0x07 parity
    base = cyc;
    q = '{8'h07}; write_seq(q); wait_idle();
    s1 = find(1, base, 3, 1'b0);
    chk("07_even_par", (sample(1, s1, 10) >> 9) & 1, 1);
    s1 = find(2, base, 3, 1'b0);
    chk("07_odd_par", (sample(2, s1, 10) >> 9) & 1, 0);

    // back-to-back
    base = cyc; rc0 = rencnt[0]; dc0 = donecnt[0];
    q = '{8'h00, 8'hFF, 8'h3C}; write_seq(q); wait_idle();
    chk("b2b_pops", rencnt[0] - rc0, 3);
    chk("b2b_dones", donecnt[0] - dc0, 3);
    s = find(0, base, 3, 1'b0);
    d = find(0, s, 0, 1'b1);
    s2 = find(0, d, 3, 1'b0);
    chk("b2b_gap", s2 - d, 3);
    chk("b2b_byte0", get_byte(0, s), 8'h00);
    chk("b2b_byte1", get_byte(0, s2), 8'hFF);

    // fill to 16 while held in reset, then drain
    rst = 1'b1;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(2 * i));
    write_seq(q);
    @(negedge clk);
    chk("fill_full", fcnt[0], 16);
    base = cyc; dc0 = donecnt[0];
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_clears", fcnt[0], 15);
    wait_idle();
    chk("fill_dones", donecnt[0] - dc0, 16);
    s = base;
    for (int i = 0; i < 16; i++) begin
      s = find(0, s, 3, 1'b0);
      chk($sformatf("fill_byte%0d", i), get_byte(0, s), 2 * i);
      s = find(0, s, 0, 1'b1) + 1;
    end

    // reset mid data bit 3 of 0x5A
    base = cyc; rc0 = rencnt[0]; dc0 = donecnt[0];
    q = '{8'h5A, 8'h11}; write_seq(q);
    s = -1;
    for (int i = 0; i < 30 && s < 0; i++) begin
      s = find(0, base, 3, 1'b0);
      if (s < 0) @(negedge clk);
    end
    chk("5a_started", int'(s >= 0), 1);
    for (int i = 0; i < 40 && cyc < s + 17; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("rst_async_tx%0d", l), int'(tx[l]), 1);
      chk($sformatf("rst_async_busy%0d", l), int'(busy[l]), 0);
      chk($sformatf("rst_async_r_en%0d", l), int'(ren[l]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rb = cyc;
    wait_idle();
    s2 = find(0, rb, 3, 1'b0);
    chk("after_rst_byte", get_byte(0, s2), 8'h11);
    chk("after_rst_dones", donecnt[0] - dc0, 1);
    chk("after_rst_pops", rencnt[0] - rc0, 2);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
